regfile_wb_scoreboard: RTL and testbench

- Write-side consumer of the writeback stage's output bus (WB_dest / WB_value / WB_WEenable).
- Holds the 32-entry architectural register file and provides two read ports to decode.
- Tracks in-flight writes per register in a scoreboard and raises a decode stall on a RAW hazard against a pending write.
- Sits between the WB stage output flops and the decode/issue stage.

---
 rtl/regfile_wb_scoreboard_if.sv | 32 +++
 rtl/regfile_wb_scoreboard.sv | 103 ++++++++++
 tb/tb_regfile_wb_scoreboard.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scoreboard_if.sv
// Bus between the writeback stage, decode/issue, and the register file scoreboard.
// The master side is WB plus decode; the register file is the slave.
interface regfile_wb_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        WB_dest;
  logic [DATA_W-1:0] WB_value;
  logic              WB_WEenable;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              issue_valid;
  logic              issue_we;
  logic [4:0]        issue_dest;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              stall;
  logic              pend_any;

  modport master (
    output WB_dest, WB_value, WB_WEenable, rs_addr, rt_addr, rs_used, rt_used,
           issue_valid, issue_we, issue_dest,
    input  rs_data, rt_data, stall, pend_any
  );

  modport slave (
    input  WB_dest, WB_value, WB_WEenable, rs_addr, rt_addr, rs_used, rt_used,
           issue_valid, issue_we, issue_dest,
    output rs_data, rt_data, stall, pend_any
  );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// 32-entry register file with per-register pending-write scoreboard and RAW stall.
// Define REGFILE_BYPASS_EN for WB write-through on reads and same-cycle hazard release.

// One pending-write counter; holds at zero on a WB with nothing outstanding.
module regfile_wb_pend_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic [PEND_W-1:0] cnt_nxt
);
  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec)                    cnt_nxt = cnt + PEND_W'(1);
    else if (dec && !inc && cnt != '0)  cnt_nxt = cnt - PEND_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_nxt;
  end
endmodule

module regfile_wb_scoreboard #(
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  regfile_wb_scoreboard_if.slave bus
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs     [32];
  logic [PEND_W-1:0] pend     [32];
  logic [PEND_W-1:0] pend_nxt [32];
  logic [31:0]       wb_hit, busy, inc;
  logic              sat, fire, pend_any_nxt, pend_any_q;

  always_comb begin
    wb_hit = '0;
    busy   = '0;
    for (int r = 1; r < 32; r++) begin
      wb_hit[r] = bus.WB_WEenable && (bus.WB_dest == 5'(r));
`ifdef REGFILE_BYPASS_EN
      // A WB with nothing pending must not make the register look busy.
      busy[r]   = pend[r] > PEND_W'(wb_hit[r]);
`else
      busy[r]   = pend[r] != '0;
`endif
    end
  end

  always_comb begin
    sat = bus.issue_we && (bus.issue_dest != '0) &&
          (pend[bus.issue_dest] == PEND_MAX) && !wb_hit[bus.issue_dest];
    bus.stall = bus.issue_valid && ((bus.rs_used && busy[bus.rs_addr]) ||
                                    (bus.rt_used && busy[bus.rt_addr]) || sat);
    fire = bus.issue_valid && !bus.stall && bus.issue_we && (bus.issue_dest != '0);
  end

  always_comb begin
    inc          = '0;
    pend_any_nxt = 1'b0;
    for (int r = 1; r < 32; r++) inc[r] = fire && (bus.issue_dest == 5'(r));
    for (int r = 0; r < 32; r++) pend_any_nxt = pend_any_nxt || (pend_nxt[r] != '0);
  end

  for (genvar r = 0; r < 32; r++) begin : g_pend
    regfile_wb_pend_cnt #(.PEND_W(PEND_W)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (inc[r]),
      .dec     (wb_hit[r]),
      .cnt     (pend[r]),
      .cnt_nxt (pend_nxt[r])
    );
  end

  always_comb begin
    bus.rs_data = (bus.rs_addr == '0) ? '0 : regs[bus.rs_addr];
    bus.rt_data = (bus.rt_addr == '0) ? '0 : regs[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit[bus.rs_addr]) bus.rs_data = bus.WB_value;
    if (wb_hit[bus.rt_addr]) bus.rt_data = bus.WB_value;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) regs[r] <= '0;
      pend_any_q <= 1'b0;
    end else begin
      if (bus.WB_WEenable && bus.WB_dest != '0) regs[bus.WB_dest] <= bus.WB_value;
      pend_any_q <= pend_any_nxt;
    end
  end

  assign bus.pend_any = pend_any_q;
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed vector table plus randomized run against a queue-free arithmetic model.
module tb_regfile_wb_scoreboard;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int PMAX = 3;

  typedef struct {
    logic rst_n, we; logic [4:0] dest; logic [31:0] val;
    logic [4:0] rs, rt; logic rsu, rtu, iv, iwe; logic [4:0] idest;
    logic [31:0] ers, ert; logic estall, epa;
  } vec_t;

  logic clock, reset_n;
  int   errors = 0, checks = 0;
  regfile_wb_scoreboard_if #(.DATA_W(32)) bus ();

  regfile_wb_scoreboard #(.DATA_W(32), .PEND_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(logic rst_n, logic we, logic [4:0] dest, logic [31:0] val,
                              logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
                              logic iv, logic iwe, logic [4:0] idest,
                              logic [31:0] ers, logic [31:0] ert, logic estall, logic epa);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.dest = dest; v.val = val; v.rs = rs; v.rt = rt;
    v.rsu = rsu; v.rtu = rtu; v.iv = iv; v.iwe = iwe; v.idest = idest;
    v.ers = ers; v.ert = ert; v.estall = estall; v.epa = epa;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset_n = v.rst_n;
    bus.WB_WEenable = v.we; bus.WB_dest = v.dest; bus.WB_value = v.val;
    bus.rs_addr = v.rs; bus.rt_addr = v.rt; bus.rs_used = v.rsu; bus.rt_used = v.rtu;
    bus.issue_valid = v.iv; bus.issue_we = v.iwe; bus.issue_dest = v.idest;
  endtask

  vec_t tbl [23];
  vec_t idle;
  logic [31:0] regs_m [32];
  int          pend_m [32];
  logic        pa_m;

  initial begin
    idle = mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0);
    tbl[0]  = mk(1,1,5,32'hDEADBEEF, 5,5,0,0, 0,0,0, BYP ? 32'hDEADBEEF : 0, BYP ? 32'hDEADBEEF : 0, 0,0);
    tbl[1]  = mk(1,0,0,0, 5,5,0,0, 0,0,0, 32'hDEADBEEF, 32'hDEADBEEF, 0,0);
    tbl[2]  = mk(1,0,0,0, 0,0,0,0, 1,1,7, 0,0,0,0);
    tbl[3]  = mk(1,0,0,0, 7,0,1,0, 1,0,0, 0,0,1,1);
    tbl[4]  = mk(1,1,7,32'h1234, 7,0,1,0, 1,0,0, BYP ? 32'h1234 : 0, 0, !BYP, 1);
    tbl[5]  = mk(1,0,0,0, 7,7,1,1, 1,0,0, 32'h1234, 32'h1234, 0,0);
    tbl[6]  = mk(1,0,0,0, 0,0,0,0, 1,1,3, 0,0,0,0);
    tbl[7]  = mk(1,0,0,0, 0,0,0,0, 1,1,3, 0,0,0,1);
    tbl[8]  = mk(1,0,0,0, 0,0,0,0, 1,1,3, 0,0,0,1);
    tbl[9]  = mk(1,0,0,0, 0,0,0,0, 1,1,3, 0,0,1,1);
    tbl[10] = mk(1,1,3,32'hAA, 3,0,0,0, 1,1,3, BYP ? 32'hAA : 0, 0, 0,1);
    tbl[11] = mk(1,0,0,0, 3,0,0,0, 1,1,3, 32'hAA, 0, 1,1);
    tbl[12] = mk(1,1,3,32'h11, 3,0,0,0, 0,0,0, BYP ? 32'h11 : 32'hAA, 0, 0,1);
    tbl[13] = mk(1,1,3,32'h22, 3,0,0,0, 0,0,0, BYP ? 32'h22 : 32'h11, 0, 0,1);
    tbl[14] = mk(1,1,3,32'h33, 3,0,0,0, 0,0,0, BYP ? 32'h33 : 32'h22, 0, 0,1);
    tbl[15] = mk(1,1,0,32'hFFFFFFFF, 0,3,0,0, 0,0,0, 0, 32'h33, 0,0);
    tbl[16] = mk(1,0,0,0, 0,0,1,1, 1,1,0, 0,0,0,0);
    tbl[17] = mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0);
    tbl[18] = mk(1,1,9,32'h99, 0,0,0,0, 0,0,0, 0,0,0,0);
    tbl[19] = mk(1,0,0,0, 9,0,1,0, 1,0,0, 32'h99, 0, 0,0);
    tbl[20] = mk(1,0,0,0, 0,0,0,0, 1,1,9, 0,0,0,0);
    tbl[21] = mk(0,1,9,32'h55, 0,0,0,0, 0,0,0, 0,0,0,1);
    tbl[22] = mk(1,0,0,0, 9,5,1,1, 1,0,0, 0,0,0,0);

    // Reset and inspect every register through both ports.
    drive(idle);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      bus.rs_addr = 5'(r); bus.rt_addr = 5'(31 - r);
      bus.issue_valid = 1'b1; bus.rs_used = 1'b1; bus.rt_used = 1'b1;
      #1;
      check($sformatf("reset_rs_r%0d", r), bus.rs_data, 0);
      check($sformatf("reset_rt_r%0d", 31 - r), bus.rt_data, 0);
      check("reset_stall", 32'(bus.stall), 0);
      check("reset_pend_any", 32'(bus.pend_any), 0);
    end
    drive(idle);
    @(posedge clock); #1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d_rs_data", i), bus.rs_data, tbl[i].ers);
      check($sformatf("vec%0d_rt_data", i), bus.rt_data, tbl[i].ert);
      check($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(tbl[i].estall));
      check($sformatf("vec%0d_pend_any", i), 32'(bus.pend_any), 32'(tbl[i].epa));
      @(posedge clock); #1;
    end

    // Randomized run against the model, starting from a fresh reset.
    drive(idle);
    reset_n = 1'b0;
    @(posedge clock); #1;
    for (int r = 0; r < 32; r++) begin regs_m[r] = 0; pend_m[r] = 0; end
    pa_m = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      logic [31:0] ers, ert;
      logic        est, fire;
      int          p_hit_rs, p_hit_rt, np;
      bit          hit_rs, hit_rt, hit_id, sat;
      v = idle;
      v.rst_n = ($urandom_range(63) != 0);
      v.we = 1'($urandom_range(1)); v.dest = 5'($urandom_range(7)); v.val = $urandom;
      v.rs = 5'($urandom_range(7)); v.rt = 5'($urandom_range(7));
      v.rsu = 1'($urandom_range(1)); v.rtu = 1'($urandom_range(1));
      v.iv = ($urandom_range(3) != 0); v.iwe = 1'($urandom_range(1));
      v.idest = 5'($urandom_range(7));
      drive(v);
      #1;
      hit_rs = v.we && v.dest == v.rs && v.rs != 0;
      hit_rt = v.we && v.dest == v.rt && v.rt != 0;
      hit_id = v.we && v.dest == v.idest && v.idest != 0;
      ers = (v.rs == 0) ? 0 : (BYP && hit_rs) ? v.val : regs_m[v.rs];
      ert = (v.rt == 0) ? 0 : (BYP && hit_rt) ? v.val : regs_m[v.rt];
      p_hit_rs = pend_m[v.rs] - ((BYP && hit_rs) ? 1 : 0);
      p_hit_rt = pend_m[v.rt] - ((BYP && hit_rt) ? 1 : 0);
      sat  = v.iwe && v.idest != 0 && pend_m[v.idest] == PMAX && !hit_id;
      est  = v.iv && ((v.rsu && p_hit_rs > 0) || (v.rtu && p_hit_rt > 0) || sat);
      fire = v.iv && !est && v.iwe && v.idest != 0;
      check($sformatf("rnd%0d_rs_data", c), bus.rs_data, ers);
      check($sformatf("rnd%0d_rt_data", c), bus.rt_data, ert);
      check($sformatf("rnd%0d_stall", c), 32'(bus.stall), 32'(est));
      check($sformatf("rnd%0d_pend_any", c), 32'(bus.pend_any), 32'(pa_m));
      if (!v.rst_n) begin
        for (int r = 0; r < 32; r++) begin regs_m[r] = 0; pend_m[r] = 0; end
        pa_m = 1'b0;
      end else begin
        pa_m = 1'b0;
        for (int r = 1; r < 32; r++) begin
          np = pend_m[r] + ((fire && v.idest == r) ? 1 : 0) - ((v.we && v.dest == r) ? 1 : 0);
          pend_m[r] = (np < 0) ? 0 : np;
          if (pend_m[r] > 0) pa_m = 1'b1;
        end
        if (v.we && v.dest != 0) regs_m[v.dest] = v.val;
      end
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
